// File: rtl/da_input_slicer.sv
// da_input_slicer: holds the 64-tap input delay line of a distributed-arithmetic
// FIR and streams one bit-slice beat per sample bit, LSB first, as eight 8-bit
// ROM addresses plus first/last markers for the DA accumulator.
module da_input_slicer #(
    parameter int DATA_W        = 16,
    parameter int NUM_BANKS     = 8,
    parameter int TAPS_PER_BANK = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] x_in,
    input  logic              valid_in,
    output logic              in_ready,
    input  logic              clear,
    output logic [7:0]        A7,
    output logic [7:0]        A6,
    output logic [7:0]        A5,
    output logic [7:0]        A4,
    output logic [7:0]        A3,
    output logic [7:0]        A2,
    output logic [7:0]        A1,
    output logic [7:0]        A0,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_first,
    output logic              out_last,
    output logic [4:0]        bit_idx
);

    localparam int         NUM_TAPS = NUM_BANKS * TAPS_PER_BANK;
    // Width of the bit select into one tap; the counter itself is always 5 bits.
    localparam int         SEL_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [4:0] LAST_IDX = 5'(DATA_W - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SLICE = 1'b1
    } state_t;

    state_t                                  state_r;
    logic [4:0]                              bit_cnt_r;
    logic [DATA_W-1:0]                       tap_r [NUM_TAPS];
    logic [SEL_W-1:0]                        sel_s;
    logic [NUM_BANKS-1:0][TAPS_PER_BANK-1:0] addr_s;

    assign sel_s = bit_cnt_r[SEL_W-1:0];

    // Control FSM, bit counter and delay line; clear only acts while idle so a
    // running beat sequence always completes on the data it started with.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            bit_cnt_r <= 5'd0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                tap_r[i] <= '0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (clear) begin
                        for (int i = 0; i < NUM_TAPS; i++) begin
                            tap_r[i] <= '0;
                        end
                        state_r <= IDLE;
                    end else if (valid_in) begin
                        for (int i = NUM_TAPS - 1; i > 0; i--) begin
                            tap_r[i] <= tap_r[i-1];
                        end
                        tap_r[0]  <= x_in;
                        bit_cnt_r <= 5'd0;
                        state_r   <= SLICE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SLICE: begin
                    if (out_ready) begin
                        if (bit_cnt_r == LAST_IDX) begin
                            bit_cnt_r <= 5'd0;
                            state_r   <= IDLE;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    bit_cnt_r <= 5'd0;
                end
            endcase
        end
    end

    // Handshake and marker decode from the registered state only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_first = 1'b0;
        out_last  = 1'b0;
        bit_idx   = bit_cnt_r;
        if (state_r == SLICE) begin
            out_valid = 1'b1;
            out_first = (bit_cnt_r == 5'd0);
            out_last  = (bit_cnt_r == LAST_IDX);
        end else begin
            in_ready = 1'b1;
        end
    end

    // Bit-slice gather: bank k, address bit j is the current bit of tap 8k+j;
    // addresses are forced to zero whenever no beat is being presented.
    always_comb begin
        addr_s = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            for (int j = 0; j < TAPS_PER_BANK; j++) begin
                if (state_r == SLICE) begin
                    addr_s[k][j] = tap_r[k*TAPS_PER_BANK + j][sel_s];
                end else begin
                    addr_s[k][j] = 1'b0;
                end
            end
        end
    end

    assign A0 = addr_s[0];
    assign A1 = addr_s[1];
    assign A2 = addr_s[2];
    assign A3 = addr_s[3];
    assign A4 = addr_s[4];
    assign A5 = addr_s[5];
    assign A6 = addr_s[6];
    assign A7 = addr_s[7];

endmodule

// File: tb/tb_da_input_slicer.sv
// Directed bench for da_input_slicer (DATA_W = 16): a vector table of samples
// with hand-computed A0 values at beats 0, 7 and 15, plus hand-written
// sequences for back-pressure, clear, reset and delay-line propagation.
module tb_da_input_slicer;

    logic        clk;
    logic        reset;
    logic [15:0] x_in;
    logic        valid_in;
    logic        in_ready;
    logic        clear;
    logic [7:0]  A7, A6, A5, A4, A3, A2, A1, A0;
    logic        out_valid;
    logic        out_ready;
    logic        out_first;
    logic        out_last;
    logic [4:0]  bit_idx;
    logic [63:0] a_all;

    int checks   = 0;
    int failures = 0;

    logic [63:0] cap [16];

    typedef struct {
        logic [15:0] x;
        logic [7:0]  a0_b0;
        logic [7:0]  a0_b7;
        logic [7:0]  a0_b15;
    } vec_t;

    vec_t vecs [6];

    da_input_slicer #(.DATA_W(16), .NUM_BANKS(8), .TAPS_PER_BANK(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .x_in      (x_in),
        .valid_in  (valid_in),
        .in_ready  (in_ready),
        .clear     (clear),
        .A7        (A7),
        .A6        (A6),
        .A5        (A5),
        .A4        (A4),
        .A3        (A3),
        .A2        (A2),
        .A1        (A1),
        .A0        (A0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_first (out_first),
        .out_last  (out_last),
        .bit_idx   (bit_idx)
    );

    assign a_all = {A7, A6, A5, A4, A3, A2, A1, A0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        chk({name, "_in_ready"},  64'(in_ready),  64'd1);
        chk({name, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({name, "_first"},     64'(out_first), 64'd0);
        chk({name, "_last"},      64'(out_last),  64'd0);
        chk({name, "_bit_idx"},   64'(bit_idx),   64'd0);
        chk({name, "_addr"},      a_all,          64'd0);
    endtask

    // Offer one sample, collect its 16 beats into cap[], optionally stalling
    // at one beat and optionally holding clear high for the whole sequence.
    task automatic send(input logic [15:0] x, input int stall_beat, input int stall_len,
                        input logic clr);
        int beats;
        int cyc;
        chk("accept_ready", 64'(in_ready), 64'd1);
        x_in      = x;
        valid_in  = 1'b1;
        out_ready = 1'b1;
        step();
        valid_in = 1'b0;
        x_in     = 16'h0000;
        clear    = clr;
        beats    = 0;
        cyc      = 0;
        while (beats < 16 && cyc < 40) begin
            if (out_valid) begin
                chk("beat_busy",  64'(in_ready),  64'd0);
                chk("beat_idx",   64'(bit_idx),   64'(beats));
                chk("beat_first", 64'(out_first), 64'(beats == 0));
                chk("beat_last",  64'(out_last),  64'(beats == 15));
                cap[beats] = a_all;
                if (beats == stall_beat) begin
                    out_ready = 1'b0;
                    for (int s = 0; s < stall_len; s++) begin
                        step();
                        chk("stall_addr",  a_all,             cap[beats]);
                        chk("stall_idx",   64'(bit_idx),      64'(beats));
                        chk("stall_valid", 64'(out_valid),    64'd1);
                        cyc++;
                    end
                    out_ready = 1'b1;
                end
                beats++;
            end else begin
                chk("beat_valid", 64'(out_valid), 64'd1);
            end
            step();
            cyc++;
        end
        clear = 1'b0;
        chk("beat_count",  64'(beats),     64'd16);
        chk("beat_cycles", 64'(cyc),       64'(16 + ((stall_beat >= 0) ? stall_len : 0)));
        chk("ready_back",  64'(in_ready),  64'd1);
        chk("idle_valid",  64'(out_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        x_in      = 16'h0000;
        valid_in  = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b1;

        // Newest tap first: A0[j] is bit b of tap j at beat b, starting from zero taps.
        vecs[0] = '{x: 16'h0001, a0_b0: 8'h01, a0_b7: 8'h00, a0_b15: 8'h00};
        vecs[1] = '{x: 16'h8000, a0_b0: 8'h02, a0_b7: 8'h00, a0_b15: 8'h01};
        vecs[2] = '{x: 16'h0080, a0_b0: 8'h04, a0_b7: 8'h01, a0_b15: 8'h02};
        vecs[3] = '{x: 16'hFFFF, a0_b0: 8'h09, a0_b7: 8'h03, a0_b15: 8'h05};
        vecs[4] = '{x: 16'h1234, a0_b0: 8'h12, a0_b7: 8'h06, a0_b15: 8'h0A};
        vecs[5] = '{x: 16'h0000, a0_b0: 8'h24, a0_b7: 8'h0C, a0_b15: 8'h14};

        // Reset for two cycles, then idle outputs.
        step();
        step();
        reset = 1'b0;
        check_idle("reset");

        // Single impulse: only A0 bit 0 on beat 0.
        send(16'h0001, -1, 0, 1'b0);
        for (int b = 0; b < 16; b++) begin
            chk("impulse_addr", cap[b], (b == 0) ? 64'h01 : 64'h00);
        end

        // Negative sample after a clear: only the sign beat shows A0 bit 0.
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_idle_valid", 64'(out_valid), 64'd0);
        send(16'h8000, -1, 0, 1'b0);
        for (int b = 0; b < 16; b++) begin
            chk("negative_addr", cap[b], (b == 15) ? 64'h01 : 64'h00);
        end

        // Vector table from a cleared delay line.
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int v = 0; v < 6; v++) begin
            send(vecs[v].x, -1, 0, 1'b0);
            chk("table_b0",  cap[0],  {56'd0, vecs[v].a0_b0});
            chk("table_b7",  cap[7],  {56'd0, vecs[v].a0_b7});
            chk("table_b15", cap[15], {56'd0, vecs[v].a0_b15});
        end

        // Back-pressure at bit 3 for 5 cycles.
        clear = 1'b1;
        step();
        clear = 1'b0;
        send(16'h0008, 3, 5, 1'b0);
        for (int b = 0; b < 16; b++) begin
            chk("stall_data", cap[b], (b == 3) ? 64'h01 : 64'h00);
        end

        // clear together with valid_in in IDLE: sample refused, taps zeroed.
        send(16'hFFFF, -1, 0, 1'b0);
        x_in     = 16'h0001;
        valid_in = 1'b1;
        clear    = 1'b1;
        step();
        valid_in = 1'b0;
        clear    = 1'b0;
        x_in     = 16'h0000;
        chk("clrvalid_ready", 64'(in_ready),  64'd1);
        chk("clrvalid_valid", 64'(out_valid), 64'd0);
        send(16'h0000, -1, 0, 1'b0);
        for (int b = 0; b < 16; b++) begin
            chk("clrvalid_taps", cap[b], 64'h00);
        end

        // clear held during SLICE: beats and taps unaffected.
        send(16'h000F, -1, 0, 1'b1);
        for (int b = 0; b < 16; b++) begin
            chk("clrslice_addr", cap[b], (b < 4) ? 64'h01 : 64'h00);
        end
        send(16'h0000, -1, 0, 1'b0);
        for (int b = 0; b < 16; b++) begin
            chk("clrslice_kept", cap[b], (b < 4) ? 64'h02 : 64'h00);
        end

        // Reset at bit_idx 7 abandons the sample and zeroes the taps.
        x_in      = 16'hFFFF;
        valid_in  = 1'b1;
        out_ready = 1'b1;
        step();
        valid_in = 1'b0;
        x_in     = 16'h0000;
        repeat (7) step();
        chk("pre_reset_idx", 64'(bit_idx), 64'd7);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle("midreset");
        send(16'h0000, -1, 0, 1'b0);
        for (int b = 0; b < 16; b++) begin
            chk("midreset_taps", cap[b], 64'h00);
        end

        // Delay-line propagation: 0xFFFF reaches tap 63 after 63 more samples.
        for (int n = 0; n < 64; n++) begin
            send((n == 0) ? 16'hFFFF : 16'h0000, -1, 0, 1'b0);
        end
        for (int b = 0; b < 16; b++) begin
            chk("tap63_addr", cap[b], 64'h8000_0000_0000_0000);
        end
        send(16'h0000, -1, 0, 1'b0);
        for (int b = 0; b < 16; b++) begin
            chk("tap63_gone", cap[b], 64'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
